// File: rtl/cgol_frame_scheduler.sv
`timescale 1ns/1ps
// Game of Life display sequencer: seeds buffer 0, streams every frame pixel to the
// WS2812B serializer, holds the latch gap and generation period, then swaps buffers.
module cgol_frame_scheduler #(
  parameter int NUM_PIXELS   = 64,
  parameter int LATCH_CYCLES = 4000,
  parameter int GEN_PERIOD   = 6000000,
  parameter int AW           = $clog2(NUM_PIXELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          seed_start,
  input  logic          seed_done,
  output logic          gen_start,
  input  logic          gen_done,
  output logic          buf_sel,
  output logic [AW-1:0] pixel_addr,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [15:0]   frame_count,
  output logic          busy
);
  localparam int PW = $clog2(GEN_PERIOD + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [AW-1:0] LAST_PIX   = AW'(NUM_PIXELS - 1);
  localparam logic [PW-1:0] PERIOD_END = PW'(GEN_PERIOD - 1);
  localparam logic [LW-1:0] LATCH_LOAD = LW'(LATCH_CYCLES - 1);

  typedef enum logic [3:0] {
    SEED_REQ, SEED_WAIT, ADDR, OFFER, DRAIN, LATCH, PERIOD, GEN, SWAP
  } state_t;

  state_t        state;
  logic [1:0]    run_sync;
  logic [PW-1:0] period_cnt;
  logic [LW-1:0] latch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEED_REQ;
      run_sync    <= '0;
      period_cnt  <= '0;
      latch_cnt   <= '0;
      seed_start  <= 1'b0;
      gen_start   <= 1'b0;
      buf_sel     <= 1'b0;
      pixel_addr  <= '0;
      tx_valid    <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      run_sync   <= {run_sync[0], run};
      seed_start <= 1'b0;
      gen_start  <= 1'b0;
      busy       <= 1'b1;
      // Free-running since the last frame start; saturates at the period end.
      if (period_cnt < PERIOD_END) period_cnt <= period_cnt + PW'(1);
      case (state)
        SEED_REQ: begin
          seed_start <= 1'b1;
          state      <= SEED_WAIT;
        end
        SEED_WAIT: if (seed_done && !seed_start) begin
          period_cnt <= '0;
          pixel_addr <= '0;
          state      <= ADDR;
        end
        ADDR: begin
          tx_valid <= 1'b1;
          state    <= OFFER;
        end
        OFFER: if (tx_valid && tx_ready) begin
          tx_valid <= 1'b0;
          if (pixel_addr < LAST_PIX) begin
            pixel_addr <= pixel_addr + AW'(1);
            state      <= ADDR;
          end else begin
            state <= DRAIN;
          end
        end
        // tx_ready returning high means the final pixel has left the shifter.
        DRAIN: if (tx_ready) begin
          latch_cnt <= LATCH_LOAD;
          state     <= LATCH;
        end
        LATCH: begin
          if (latch_cnt == '0) begin
            busy  <= 1'b0;
            state <= PERIOD;
          end else begin
            latch_cnt <= latch_cnt - LW'(1);
          end
        end
        PERIOD: begin
          busy <= 1'b0;
          if (period_cnt >= PERIOD_END) begin
            busy <= 1'b1;
            if (run_sync[1]) begin
              gen_start <= 1'b1;
              state     <= GEN;
            end else begin
              period_cnt <= '0;
              pixel_addr <= '0;
              state      <= ADDR;
            end
          end
        end
        // A gen_done coincident with our own gen_start belongs to nothing we issued.
        GEN: if (gen_done && !gen_start) state <= SWAP;
        SWAP: begin
          buf_sel     <= ~buf_sel;
          frame_count <= frame_count + 16'd1;
          period_cnt  <= '0;
          pixel_addr  <= '0;
          state       <= ADDR;
        end
        default: state <= SEED_REQ;
      endcase
    end
  end
endmodule

// File: tb/tb_cgol_frame_scheduler.sv
`timescale 1ns/1ps
// Bench for cgol_frame_scheduler: protocol-level model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_cgol_frame_scheduler;
  localparam int NP = 4, LC = 5, GP = 40, AW = 2;

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic seed_done = 1'b0, gen_done = 1'b0, tx_ready = 1'b1;
  logic seed_start, gen_start, buf_sel, tx_valid, busy;
  logic [AW-1:0] pixel_addr;
  logic [15:0] frame_count;

  int n_cmp = 0, n_bad = 0;

  cgol_frame_scheduler #(.NUM_PIXELS(NP), .LATCH_CYCLES(LC), .GEN_PERIOD(GP)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .seed_start(seed_start), .seed_done(seed_done),
    .gen_start(gen_start), .gen_done(gen_done),
    .buf_sel(buf_sel), .pixel_addr(pixel_addr),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int lo);
    n_cmp++;
    if (act < lo) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected >= %0d", name, act, lo);
    end
  endtask

  // Protocol model: pixel order, hold-until-handshake, latch gap, frame and
  // generation spacing, and the frame_count/buf_sel each new frame must show.
  int cyc = 0, exp_pix = 0, fst = -1, gap = 0, frames = 0;
  int seed_cnt = 0, gen_cnt = 0, busy_low = 0, exp_fc = 0;
  bit exp_buf = 0, gen_pend = 0, had_gen = 0, in_gap = 0;
  bit prev_v = 0, prev_hs = 0, prev_gs = 0;
  logic [AW-1:0] prev_addr = '0;
  int hs_cyc [NP];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {seed_start, gen_start, buf_sel, tx_valid, busy, pixel_addr, frame_count}, 0);
      exp_pix = 0; exp_fc = 0; exp_buf = 0; gen_pend = 0; had_gen = 0;
      in_gap = 0; prev_v = 0; prev_hs = 0; prev_gs = 0; fst = -1;
    end else begin
      if (seed_start) seed_cnt++;
      if (!busy) busy_low++;
      if (gen_start) begin
        gen_cnt++; gen_pend = 1; had_gen = 1;
        chk("gen_pulse_width", prev_gs, 0);
        if (fst >= 0) chk_min("gen_spacing", cyc - (fst - 1), GP);
      end
      if (gen_done && gen_pend && !gen_start) begin
        gen_pend = 0;
        exp_fc = (exp_fc + 1) % 65536;
        exp_buf = !exp_buf;
      end
      if (prev_hs) chk("drop_after_handshake", tx_valid, 0);
      else if (prev_v) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_addr", pixel_addr, prev_addr);
      end
      if (tx_valid && !prev_v && exp_pix == 0) begin
        frames++;
        chk("frame_count", frame_count, exp_fc);
        chk("buf_sel", buf_sel, exp_buf);
        if (in_gap) chk_min("latch_gap", gap, LC + 1);
        if (fst >= 0) begin
          if (had_gen) chk_min("frame_spacing_gen", cyc - fst, GP);
          else chk("frame_spacing_refresh", cyc - fst, GP);
        end
        fst = cyc; had_gen = 0; in_gap = 0;
      end
      if (in_gap && !tx_valid) gap++;
      if (tx_valid) chk("busy_while_tx", busy, 1);
      chk("addr_range", pixel_addr <= NP - 1, 1);
      prev_hs = tx_valid && tx_ready;
      if (prev_hs) begin
        chk("pix_order", pixel_addr, exp_pix);
        hs_cyc[exp_pix] = cyc;
        exp_pix = (exp_pix + 1) % NP;
        if (exp_pix == 0) begin in_gap = 1; gap = 0; end
      end
      prev_v = tx_valid; prev_addr = pixel_addr; prev_gs = gen_start;
    end
  end

  // Responders: seed completes 3 cycles after request, generation after 10.
  always begin
    @(negedge clk);
    if (rst_n && seed_start) begin
      repeat (3) @(posedge clk);
      #1 seed_done = 1'b1;
      @(posedge clk);
      #1 seed_done = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (rst_n && gen_start) begin
      repeat (10) @(posedge clk);
      #1 gen_done = 1'b1;
      @(posedge clk);
      #1 gen_done = 1'b0;
    end
  end

  int f0, g0, f1, s0;

  initial begin
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    // 1: seed handshake then first pixel offered from buffer 0
    for (int i = 0; i < 60 && !tx_valid; i++) @(negedge clk);
    chk("t1_first_valid", tx_valid, 1);
    chk("t1_seed_pulses", seed_cnt, 1);
    chk("t1_addr", pixel_addr, 0);
    chk("t1_buf_sel", buf_sel, 0);

    // 2: back-to-back pixels two cycles apart
    for (int i = 0; i < 40 && !in_gap; i++) @(negedge clk);
    chk("t2_frame_done", in_gap, 1);
    for (int i = 0; i < NP - 1; i++) chk("t2_hs_spacing", hs_cyc[i + 1] - hs_cyc[i], 2);

    // 3: serializer stall on pixel 2
    for (int i = 0; i < 100 && !(pixel_addr == 2 && !tx_valid); i++) @(negedge clk);
    chk("t3_found_addr2", pixel_addr, 2);
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t3_stall_valid", tx_valid, 1);
      chk("t3_stall_addr", pixel_addr, 2);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5 && pixel_addr != 3; i++) @(negedge clk);
    chk("t3_advance", pixel_addr, 3);

    // 4: evolve two generations
    @(posedge clk); #1 run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 200 && frame_count != 1; i++) @(negedge clk);
    chk("t4_fc1", frame_count, 1);
    chk("t4_buf1", buf_sel, 1);
    for (int i = 0; i < 200 && frame_count != 2; i++) @(negedge clk);
    chk("t4_fc2", frame_count, 2);
    chk("t4_buf2", buf_sel, 0);
    chk("t4_gen_cnt", gen_cnt, 2);

    // 5: frozen refresh, then run raised mid-frame
    @(posedge clk); #1 run = 1'b0;
    f0 = frames; g0 = gen_cnt;
    @(negedge clk);
    for (int i = 0; i < 400 && frames < f0 + 4; i++) @(negedge clk);
    chk_min("t5_frames", frames, f0 + 4);
    chk("t5_no_gen", gen_cnt, g0);
    chk("t5_fc", frame_count, 2);
    chk("t5_buf", buf_sel, 0);
    chk_min("t5_busy_low_seen", busy_low, 1);
    for (int i = 0; i < 100 && !(tx_valid && pixel_addr == 1); i++) @(negedge clk);
    chk("t5_mid_frame", tx_valid, 1);
    @(posedge clk); #1 run = 1'b1;
    f1 = frames;
    @(negedge clk);
    for (int i = 0; i < 100 && gen_cnt == g0; i++) @(negedge clk);
    chk("t5_gen_after_run", gen_cnt, g0 + 1);
    chk("t5_no_extra_refresh", frames, f1);
    for (int i = 0; i < 100 && frame_count != 3; i++) @(negedge clk);
    chk("t5_fc3", frame_count, 3);
    chk("t5_buf3", buf_sel, 1);
    chk("seed_once", seed_cnt, 1);

    // 6: reset mid-pixel with frame_count=1
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 300 && frame_count != 1; i++) @(negedge clk);
    chk("t6_fc1", frame_count, 1);
    @(posedge clk); #1 run = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 200 && !(tx_valid && pixel_addr == 2 && frame_count == 1); i++) @(negedge clk);
    chk("t6_offer_addr2", {tx_valid, pixel_addr}, {1'b1, 2'd2});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", tx_valid, 0);
    chk("t6_fc_clear", frame_count, 0);
    chk("t6_buf_clear", buf_sel, 0);
    repeat (2) @(negedge clk);
    s0 = seed_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10 && seed_cnt == s0; i++) @(negedge clk);
    chk("t6_reseed", seed_cnt, s0 + 1);
    for (int i = 0; i < 60 && !tx_valid; i++) @(negedge clk);
    chk("t6_restart_addr", {tx_valid, pixel_addr}, {1'b1, 2'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cgol_frame_scheduler.md
Name: cgol_frame_scheduler

Overview:
- Top-level sequencer for the Game of Life display path.
- Orders the initial pattern load, streams each frame buffer pixel to the WS2812B serializer, enforces the WS2812B latch gap and the generation period, then triggers the next-generation engine and swaps the double buffer.
- Sits between the switch input, the frame buffers, the generation engine and the serializer driving the matrix data pin.

Parameters:
- NUM_PIXELS, 64, pixels per frame; the matrix is 8x8.
- LATCH_CYCLES, 4000, idle clocks after the last bit before the next frame (over 280 us at 12 MHz).
- GEN_PERIOD, 6000000, minimum clocks between generation starts (0.5 s at 12 MHz).
- AW, $clog2(NUM_PIXELS), pixel address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  switch level, asynchronous; synchronized internally with 2 flops. 1 = evolve, 0 = freeze and keep refreshing.
- seed_start  out  1  one-cycle pulse; requests an initial pattern write into buffer 0.
- seed_done  in  1  one-cycle pulse; seed write complete.
- gen_start  out  1  one-cycle pulse; engine reads buffer buf_sel and writes buffer ~buf_sel.
- gen_done  in  1  one-cycle pulse; next generation written.
- buf_sel  out  1  buffer currently displayed.
- pixel_addr  out  AW  frame buffer read address (synchronous read, 1-cycle latency).
- tx_valid  out  1  pixel data on the buffer read port is valid for the serializer.
- tx_ready  in  1  serializer can accept a pixel; stays low while shifting.
- frame_count  out  16  generations completed; wraps from 0xFFFF to 0.
- busy  out  1  high in every state except PERIOD.

Behaviour:
- Reset (asynchronous, immediate):
  - state = SEED_REQ.
  - All outputs 0, including buf_sel=0, frame_count=0 and pixel_addr=0.
  - Sync flops, period counter and latch counter cleared.
- SEED_REQ:
  - seed_start=1 for exactly one cycle.
  - Next state SEED_WAIT.
- SEED_WAIT:
  - Wait for seed_done.
  - Then clear the period counter, set pixel_addr=0, go to ADDR.
- ADDR:
  - tx_valid=0 for one cycle so the buffer read can complete.
  - Next state OFFER.
- OFFER:
  - tx_valid=1 and pixel_addr held stable until tx_valid&tx_ready.
  - On that handshake, if pixel_addr<NUM_PIXELS-1: pixel_addr+1, tx_valid=0, go to ADDR.
  - On the handshake of pixel NUM_PIXELS-1: go to DRAIN.
  - Minimum spacing is one pixel per 2 cycles.
- DRAIN:
  - Wait for tx_ready=1, meaning the last pixel has finished shifting.
  - Then load the latch counter and go to LATCH.
- LATCH:
  - Count LATCH_CYCLES clocks with tx_valid=0.
  - Then go to PERIOD.
- PERIOD:
  - Wait until the period counter is at least GEN_PERIOD-1.
  - The period counter increments every cycle from the last clear and saturates.
  - If synced run=1: go to GEN.
  - If synced run=0: clear the period counter, set pixel_addr=0, go to ADDR (refresh the same frame; buf_sel and frame_count unchanged).
- GEN:
  - gen_start=1 on entry for one cycle.
  - Wait for gen_done.
  - gen_done in the same cycle as gen_start is ignored.
  - run falling during GEN does not abort the generation.
- SWAP (one cycle):
  - buf_sel toggles and frame_count increments.
  - Period counter cleared, pixel_addr=0.
  - Next state ADDR.
- gen_done or seed_done outside their wait states: ignored.
- tx_ready while tx_valid=0: ignored.
- pixel_addr never exceeds NUM_PIXELS-1.
- Generation start spacing is at least GEN_PERIOD clocks and is never shorter than one full frame plus the latch gap.
- Reset during any state:
  - tx_valid drops in the same instant.
  - After release the sequence restarts at SEED_REQ.
  - Downstream blocks must tolerate an aborted pixel.

Test Plan (NUM_PIXELS=4, LATCH_CYCLES=5, GEN_PERIOD=40):
1. Release rst_n, return seed_done 3 cycles after seed_start. Required: exactly one seed_start pulse; pixel_addr=0; tx_valid rises 1 cycle after ADDR; buf_sel=0.
2. tx_ready held at 1. Required: handshakes at pixel_addr 0,1,2,3 spaced 2 cycles; then tx_valid=0 for at least 5 cycles before the next ADDR.
3. tx_ready held at 0 for 7 cycles while pixel_addr=2. Required: tx_valid stays 1 and pixel_addr stays 2 throughout; advances to 3 only after tx_ready returns.
4. run=1, gen_done 10 cycles after each gen_start. Required: gen_start no earlier than 40 cycles after the previous frame start; buf_sel toggles each generation; frame_count goes 0→1→2.
5. run=0 for 3 frames. Required: no gen_start; frame_count and buf_sel unchanged; pixels 0..3 re-sent each frame. Raise run mid-frame: gen_start in the next PERIOD exit.
6. Assert rst_n low during OFFER at pixel_addr=2 with frame_count=1. Required: tx_valid=0 immediately; frame_count=0, buf_sel=0; a new seed_start pulse after release.
